// File: rtl/subleq_core_param.sv
// subleq_core_param: parametrised SUBLEQ core on a req/resp memory port.
// mem[B] = mem[B] - mem[A]; if result <= 0 goto C else pc += 3.
//
// Parameters: DATA_W (data width), ADDR_W (address width, <= DATA_W),
//             RESET_PC (pc after reset).
// Ports:
//   clock, rst        clock; synchronous active-high reset
//   run               1 = execute, 0 = park at next instruction boundary
//   mem_req/mem_we    request valid / write enable (registered)
//   mem_addr/wdata    request address / write data (registered)
//   mem_ready         request accepted when mem_req && mem_ready
//   mem_rvalid/rdata  one read-data pulse per accepted read
//   pc                current instruction address
//   halted            stopped by a taken branch to a C with its MSB set
//   busy              FSM not in IDLE or HALT
//   instr_count       retired instructions, saturating
// Optional trace port (define SUBLEQ_TRACE_EN):
//   retire_valid, retire_pc, retire_addr, retire_data, retire_taken
module subleq_core_param #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  output logic [31:0]       instr_count
`ifdef SUBLEQ_TRACE_EN
  ,
  output logic              retire_valid,
  output logic [ADDR_W-1:0] retire_pc,
  output logic [ADDR_W-1:0] retire_addr,
  output logic [DATA_W-1:0] retire_data,
  output logic              retire_taken
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    FETCH_C,
    LOAD_A,
    LOAD_B,
    WRITE,
    HALT
  } state_t;

  state_t state;

  // Set once a read has been accepted and its data is still owed.
  logic              wait_rv;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [ADDR_W-1:0] c_tgt;
  logic              c_halt;
  logic [DATA_W-1:0] a_val;

  logic              accept;
  logic              rd_state;
  logic              rd_done;
  logic              leq;
  logic [DATA_W-1:0] diff;
  logic [ADDR_W-1:0] pc_inc3;
  logic [ADDR_W-1:0] next_pc;

  assign accept   = mem_req && mem_ready;
  assign rd_state = state inside {FETCH_A, FETCH_B, FETCH_C,
                                  LOAD_A, LOAD_B};
  // Data may arrive in the accept cycle or any later cycle.
  assign rd_done  = rd_state && mem_rvalid && (accept || wait_rv);
  assign diff     = mem_rdata - a_val;
  // mem_wdata holds diff for the whole WRITE state.
  assign leq      = mem_wdata[DATA_W-1] || (mem_wdata == '0);
  assign pc_inc3  = pc + ADDR_W'(3);
  assign next_pc  = leq ? c_tgt : pc_inc3;

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      wait_rv     <= 1'b0;
      a_addr      <= '0;
      b_addr      <= '0;
      c_tgt       <= '0;
      c_halt      <= 1'b0;
      a_val       <= '0;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      busy        <= 1'b0;
      instr_count <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef SUBLEQ_TRACE_EN
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_addr  <= '0;
      retire_data  <= '0;
      retire_taken <= 1'b0;
`endif
    end else begin
`ifdef SUBLEQ_TRACE_EN
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_addr  <= '0;
      retire_data  <= '0;
      retire_taken <= 1'b0;
`endif
      // Shared read handshake: drop the request once accepted,
      // then hold until the data pulse.
      if (rd_state) begin
        if (rd_done) begin
          wait_rv <= 1'b0;
        end else if (accept) begin
          mem_req <= 1'b0;
          wait_rv <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH_A;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        FETCH_A: begin
          if (rd_done) begin
            a_addr   <= mem_rdata[ADDR_W-1:0];
            state    <= FETCH_B;
            mem_req  <= 1'b1;
            mem_addr <= pc + ADDR_W'(1);
          end
        end
        FETCH_B: begin
          if (rd_done) begin
            b_addr   <= mem_rdata[ADDR_W-1:0];
            state    <= FETCH_C;
            mem_req  <= 1'b1;
            mem_addr <= pc + ADDR_W'(2);
          end
        end
        FETCH_C: begin
          if (rd_done) begin
            c_tgt    <= mem_rdata[ADDR_W-1:0];
            c_halt   <= mem_rdata[DATA_W-1];
            state    <= LOAD_A;
            mem_req  <= 1'b1;
            mem_addr <= a_addr;
          end
        end
        LOAD_A: begin
          if (rd_done) begin
            a_val    <= mem_rdata;
            state    <= LOAD_B;
            mem_req  <= 1'b1;
            mem_addr <= b_addr;
          end
        end
        LOAD_B: begin
          if (rd_done) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= b_addr;
            mem_wdata <= diff;
          end
        end
        WRITE: begin
          if (accept) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (instr_count != '1) begin
              instr_count <= instr_count + 32'd1;
            end
`ifdef SUBLEQ_TRACE_EN
            retire_valid <= 1'b1;
            retire_pc    <= pc;
            retire_addr  <= b_addr;
            retire_data  <= mem_wdata;
            retire_taken <= leq;
`endif
            if (leq && c_halt) begin
              halted <= 1'b1;
              busy   <= 1'b0;
              state  <= HALT;
            end else begin
              pc <= next_pc;
              if (run) begin
                state    <= FETCH_A;
                mem_req  <= 1'b1;
                mem_addr <= next_pc;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        HALT: begin
          mem_req <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
